// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU memory interface.
package cpu_pkg;
  localparam int DW = 32;
  localparam int AW = 10;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} wr_state_t;
endpackage

// File: rtl/mem_array.sv
// DEPTH x DW storage: one write port, one registered read port.
// Addresses at or beyond DEPTH read as zero and never write.
module mem_array #(
  parameter int DW    = 32,
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [DEPTH];
  logic          w_ok, r_ok;

  assign w_ok = {1'b0, wa} < DEPTH[AW:0];
  assign r_ok = {1'b0, ra} < DEPTH[AW:0];

  // Contents survive reset; only the read register clears.
  always_ff @(posedge clk)
    if (we && w_ok) mem[wa] <= wd;

  always_ff @(posedge clk) begin
    if (reset)   rd <= '0;
    else if (re) rd <= r_ok ? mem[ra] : '0;
  end
endmodule

// File: rtl/main_memory.sv
// Word-addressed main memory for the control unit: 1-cycle reads, delayed-commit writes.
// Define MAIN_MEMORY_LOAD_EN to add the host preload port (ld_en/ld_addr/ld_data).
module main_memory
  import cpu_pkg::*;
#(
  parameter int DW       = cpu_pkg::DW,
  parameter int AW       = cpu_pkg::AW,
  parameter int DEPTH    = 1024,
  parameter int WR_DELAY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          e,
  input  logic          rw,
  input  logic [AW-1:0] MAR,
  input  logic [DW-1:0] wD,
`ifdef MAIN_MEMORY_LOAD_EN
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
`endif
  output logic [DW-1:0] rD,
  output logic          busy
);
  wr_state_t     state;
  logic [2:0]    cnt;
  logic [AW-1:0] wa;
  logic          ld_act;
  logic [AW-1:0] ld_a;
  logic [DW-1:0] ld_d;
  logic          req_held, commit, we, re;
  logic [AW-1:0] arr_wa;
  logic [DW-1:0] arr_wd;

`ifdef MAIN_MEMORY_LOAD_EN
  assign ld_act = ld_en;
  assign ld_a   = ld_addr;
  assign ld_d   = ld_data;
`else
  assign ld_act = 1'b0;
  assign ld_a   = '0;
  assign ld_d   = '0;
`endif

  assign req_held = e && (rw == WRITE);
  // Host load wins the single write port; a coinciding commit waits in WAIT.
  assign commit   = (state == WAIT) && (cnt == 3'd0) && req_held && !ld_act && !reset;
  assign we       = ld_act || commit;
  assign arr_wa   = ld_act ? ld_a : wa;
  assign arr_wd   = ld_act ? ld_d : wD;
  assign re       = e && (rw == READ) && (state == IDLE) && !ld_act;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      wa    <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_held) begin
          state <= WAIT;
          wa    <= MAR;
          cnt   <= 3'(WR_DELAY - 1);
          busy  <= 1'b1;
        end
        WAIT: begin
          if (!req_held) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else if (!ld_act) begin
            state <= HOLD;
          end
        end
        // Stay here until the request level drops so one long rw=1 writes once.
        HOLD: if (!req_held) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_arr (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .wa    (arr_wa),
    .wd    (arr_wd),
    .re    (re),
    .ra    (MAR),
    .rd    (rD)
  );
endmodule

// File: doc/main_memory.md
# main_memory

- Word-addressed main memory that answers the control unit's memory interface (`e`, `rw`, `MAR`, `wD` → `rD`).
- Reads are registered, with one cycle of latency.
- Writes are captured by a small state machine. It latches the address when a write request is seen, then commits `wD` a fixed number of cycles later, which matches the control unit's late write-data drive.
- The block sits directly beside the control unit at the top level and is the only storage it addresses.

## Interface
Parameters:
- `DW`, 32: data word width.
- `AW`, 10: address width; must match `MAR`.
- `DEPTH`, 1024: implemented words; must be ≤ 2^AW.
- `WR_DELAY`, 2: cycles from write-request sample to commit; legal range 1..7.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `e` in 1: memory enable.
- `rw` in 1: 0 = read, 1 = write.
- `MAR` in AW: word address.
- `wD` in DW: write data.
- `rD` out DW: registered read data.
- `busy` out 1: high while a write is pending (WAIT) or held (HOLD).
- Only with `MAIN_MEMORY_LOAD_EN` (host preload port):
  - `ld_en` in 1
  - `ld_addr` in AW
  - `ld_data` in DW

## Operation
- **Reset.** `rD` = 0, `busy` = 0, FSM = IDLE, delay counter = 0. Array contents are not cleared.
- **Read.** On each edge with `e`=1, `rw`=0 and FSM=IDLE: `rD` <= `mem[MAR]`. Otherwise `rD` holds its value.
- **Out of range.** For `MAR` ≥ DEPTH, reads return 0 and writes are dropped.
- **Write FSM**, states IDLE, WAIT, HOLD:
  - IDLE → WAIT on an edge with `e`=1 and `rw`=1. Latch `wa` = `MAR`; set `cnt` = WR_DELAY−1.
  - WAIT with `cnt`≠0: decrement `cnt`.
  - WAIT with `cnt`=0: `mem[wa]` <= `wD` (the value sampled on that edge); go to HOLD.
  - WAIT with `rw`=0 or `e`=0 on an edge before commit: abort, no write, go to IDLE.
  - HOLD → IDLE on an edge with `rw`=0 or `e`=0. This prevents one long `rw`=1 level from re-triggering a write.
- **Changes during WAIT.** `MAR` and `wD` may change during WAIT. Only the latched `wa` and the `wD` value at the commit edge are used.
- **Widths.** Data passes through unmodified. No arithmetic is done on data; `cnt` is 3 bits.

## Timing
- **Read latency.** `MAR` presented before edge N gives `rD` valid after edge N. The control unit sets `MAR` at edge k and reads `rD` at edge k+2; this margin is required.
- **Write timing.** Request sampled at edge S; commit at edge S+WR_DELAY. With default 2, `wD` driven at edge S+1 is the committed value.
- **Read after write.** A read of `wa` issued once the FSM is back in IDLE returns the new data.
- **Reset mid-write.** Reset asserted during WAIT drops the pending write; the array is unchanged.
- **Simultaneous request and commit.** Cannot occur: a new request is only accepted in IDLE.

## Configuration
`MAIN_MEMORY_LOAD_EN`
- **Defined.**
  - Adds the `ld_*` port. On each edge with `ld_en`=1, `mem[ld_addr]` <= `ld_data`; this is honoured during reset as well, for program preload.
  - `ld_en` has priority over the FSM commit. A commit edge that coincides with `ld_en`=1 is deferred: the FSM stays in WAIT with `cnt`=0 and commits on the next edge with `ld_en`=0, using `wD` at that edge.
  - CU reads are suppressed (hold) on edges with `ld_en`=1.
- **Undefined.** The port does not exist; contents come only from CU writes or the simulator.

## Structure
- **Package `cpu_pkg`:**
  - `DW`/`AW` constants.
  - The write-FSM state enum (IDLE/WAIT/HOLD).
  - RW encoding constants (READ=0, WRITE=1).
- **Sub-module `mem_array`:**
  - Single write port, synchronous read port, DEPTH×DW.
  - Write-port mux (load vs. FSM commit) and FSM stay in `main_memory`.

## Test plan
- **Reset.** Hold `reset` 2 cycles → `rD`=0, `busy`=0. Preload `mem[5]`=0x1234 and read addr 5 → `rD`=0x1234 one edge after the request.
- **Delayed write.** Edge S: `e`=1, `rw`=1, `MAR`=0x010. Edge S+1: `wD`=0xDEADBEEF. Then `rw`=0 and read 0x010 → `rD`=0xDEADBEEF. `busy` is high from edge S until `rw` falls.
- **Abort.** `rw`=1 at `MAR`=0x020, then `rw`=0 one edge later → `mem[0x020]` unchanged, FSM back in IDLE.
- **No re-trigger.** Hold `rw`=1 for 10 cycles at `MAR`=0x030 while `wD` changes each cycle → exactly one write, of the `wD` value at edge S+2.
- **Reset mid-write.** Assert `reset` in WAIT → no write; `rD`=0; next read of that address returns the old value.
- **Load/commit collision (`MAIN_MEMORY_LOAD_EN`).** `ld_en`=1 with `ld_addr`=0x040, `ld_data`=0x55 on the commit edge of a CU write to 0x041 → `mem[0x040]`=0x55; `mem[0x041]` is written one edge later.
